// File: rtl/move_player.sv
// -----------------------------------------------------------------------------
// move_player
//
// Drains 2-bit move codes from an external queue and hands them one at a time
// to a downstream consumer over a valid/ready handshake. After the queue runs
// dry the player parks in DONE. From there it can be restarted, or it can ask
// the queue to recover its read pointer and replay the same moves.
//
// Parameters
//   CNT_W       width of move_count (saturating delivered-move counter)
//
// Ports
//   clk         single clock, all state changes on its rising edge
//   rst         synchronous active-high reset
//   start       one-cycle request to begin draining (IDLE/DONE only)
//   replay      in DONE: recover the queue and play it back again
//   q_empty     queue empty flag (registered inside the queue)
//   q_dout      queue read data, valid the cycle after a dequeue strobe
//   q_dequeue   dequeue strobe to the queue
//   q_recover   recover strobe to the queue
//   move_valid  move_dir holds a move not yet accepted
//   move_ready  consumer accepts the move on an edge where both are high
//   move_dir    move code: 00 up, 01 right, 10 down, 11 left
//   move_count  moves delivered since the last start or replay
//   busy        high in every state other than IDLE and DONE
//   done        high only in DONE
// -----------------------------------------------------------------------------
module move_player #(
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             replay,
    input  logic             q_empty,
    input  logic [1:0]       q_dout,
    output logic             q_dequeue,
    output logic             q_recover,
    output logic             move_valid,
    input  logic             move_ready,
    output logic [1:0]       move_dir,
    output logic [CNT_W-1:0] move_count,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CAPT,
        SEND,
        RCV,
        RWAIT1,
        RWAIT2,
        DONE
    } state_t;

    state_t           state_reg;
    logic [1:0]       dir_reg;
    logic [CNT_W-1:0] count_reg;
    logic             recover_reg;
    logic             valid_reg;
    logic             busy_reg;
    logic             done_reg;

    localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

    // Every output except q_dequeue is a flop loaded alongside the state
    // transition, so it changes exactly when the state does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            dir_reg     <= 2'b00;
            count_reg   <= '0;
            recover_reg <= 1'b0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    // start outranks replay when both arrive in DONE
                    if (start) begin
                        state_reg <= REQ;
                        count_reg <= '0;
                        busy_reg  <= 1'b1;
                        done_reg  <= 1'b0;
                    end else if (state_reg == DONE && replay) begin
                        state_reg   <= RCV;
                        count_reg   <= '0;
                        recover_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                        done_reg    <= 1'b0;
                    end
                end

                REQ: begin
                    if (q_empty) begin
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        state_reg <= CAPT;
                    end
                end

                // q_dout became valid this cycle because the dequeue was
                // issued in REQ on the previous edge.
                CAPT: begin
                    dir_reg   <= q_dout;
                    state_reg <= SEND;
                    valid_reg <= 1'b1;
                end

                SEND: begin
                    if (move_ready) begin
                        if (count_reg != COUNT_MAX) begin
                            count_reg <= count_reg + CNT_W'(1);
                        end
                        valid_reg <= 1'b0;
                        state_reg <= REQ;
                    end
                end

                RCV: begin
                    recover_reg <= 1'b0;
                    state_reg   <= RWAIT1;
                end

                // Two quiet cycles give the queue time to settle q_empty
                // after the pointer recovery before REQ samples it.
                RWAIT1: state_reg <= RWAIT2;
                RWAIT2: state_reg <= REQ;

                default: begin
                    state_reg   <= IDLE;
                    recover_reg <= 1'b0;
                    valid_reg   <= 1'b0;
                    busy_reg    <= 1'b0;
                    done_reg    <= 1'b0;
                end
            endcase
        end
    end

    // The dequeue must be decided in the same cycle q_empty is seen, so it
    // is decoded from the state register rather than registered itself.
    // Gating with q_empty guarantees no dequeue of an empty queue.
    assign q_dequeue  = (state_reg == REQ) && !q_empty;
    assign q_recover  = recover_reg;
    assign move_valid = valid_reg;
    assign move_dir   = dir_reg;
    assign move_count = count_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: doc/move_player.md
MOVE_PLAYER -- requirements
Module: move_player

Interface
REQ-001 Parameter CNT_W, default 9, SHALL set the width of move_count; 9 covers 256 entries.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset, sampled only on posedge clk.
REQ-004 start  input  1  SHALL be a one-cycle request to begin draining; honoured only in IDLE or DONE.
REQ-005 replay  input  1  SHALL be sampled in DONE to request a queue recover plus a second playback.
REQ-006 q_empty  input  1  SHALL be the queue empty flag (registered in the queue).
REQ-007 q_dout  input  2  SHALL be the queue read data, valid the cycle after a dequeue pulse.
REQ-008 q_dequeue  output  1  SHALL be the dequeue strobe to the queue.
REQ-009 q_recover  output  1  SHALL be the recover strobe to the queue.
REQ-010 move_valid  output  1  SHALL flag that move_dir holds an undelivered move.
REQ-011 move_ready  input  1  SHALL be asserted by the downstream consumer to accept a move.
REQ-012 move_dir  output  2  SHALL be the move code (00 up, 01 right, 10 down, 11 left), passed through unmodified.
REQ-013 move_count  output  CNT_W  SHALL count moves delivered since the last start or replay.
REQ-014 busy  output  1  SHALL be high in every state except IDLE and DONE.
REQ-015 done  output  1  SHALL be high only in DONE.

Function
REQ-016 States SHALL be IDLE, REQ, CAPT, SEND, RCV, RWAIT1, RWAIT2, DONE.
REQ-017 IDLE/DONE + start=1 -> REQ; move_count cleared to 0; in DONE, start takes priority over replay.
REQ-018 REQ: if q_empty=1, go to DONE with no strobe; else assert q_dequeue for exactly this cycle and go to CAPT.
REQ-019 CAPT: latch q_dout into move_dir at the clock edge; go to SEND.
REQ-020 SEND: move_valid=1; move_dir stable until the handshake completes.
REQ-021 Handshake: a transfer SHALL occur on the edge where move_valid=1 and move_ready=1; then move_count increments and the state goes to REQ.
REQ-022 move_ready SHALL be allowed high before move_valid; a transfer still needs both high on the same edge.
REQ-023 Dequeue pulses SHALL be separated by at least 3 cycles (REQ->CAPT->SEND->REQ), so q_empty is current when re-sampled.
REQ-024 q_dequeue SHALL never be asserted while q_empty=1.
REQ-025 DONE + replay=1 (start=0) -> RCV; q_recover asserted for exactly the RCV cycle.
REQ-026 RCV -> RWAIT1 -> RWAIT2 -> REQ; move_count cleared on entering RCV; no strobes in the RWAIT states.
REQ-027 q_recover and q_dequeue SHALL never be asserted in the same cycle.
REQ-028 move_count SHALL saturate at 2^CNT_W-1; no wrap.
REQ-029 start or replay in any busy state SHALL be ignored.
REQ-030 move_valid SHALL be low in every state except SEND; done and busy are mutually exclusive.

Reset
REQ-031 rst=1 at any edge SHALL force IDLE, including mid-handshake or mid-recover; rst overrides all other inputs.
REQ-032 Reset values: q_dequeue=0, q_recover=0, move_valid=0, move_dir=00, move_count=0, busy=0, done=0.
REQ-033 A move in SEND and not yet accepted when rst asserts SHALL be discarded; no re-issue after reset.

Verification
REQ-034 Queue holds 10,11,01; start; move_ready=1 -> moves 10,11,01 in order, 3 dequeue pulses each 3 cycles apart, then DONE, move_count=3.
REQ-035 start with the queue empty -> REQ then DONE, zero q_dequeue pulses, move_count=0, done=1.
REQ-036 Queue holds 00; move_ready held low 5 cycles in SEND -> move_valid=1 and move_dir=00 stable for 5 cycles; transfer on the first move_ready=1 edge.
REQ-037 After draining 2 entries (01,10), replay=1 in DONE -> one q_recover pulse, 2 idle cycles, then 01,10 replayed; move_count=2.
REQ-038 rst=1 while in SEND with move_valid=1 -> next cycle IDLE, all outputs at reset values; a later start resumes with the remaining queue entries.
REQ-039 start and replay both high in DONE -> start wins: no q_recover pulse, move_count=0, state REQ.
